bram_bank_wr_demux: RTL and testbench
=====================================

# bram_bank_wr_demux

Registered write demultiplexer that steers a linear feature-map/weight write stream into `BANK_NUM` per-pixel BRAM banks. The bank is selected by an address field, and the in-bank address comes from the low bits. It sits between the DMA/AXI write path and the CNN input buffer banks. It extends the combinational bank mux with the following:
- valid/ready handshake
- one-cycle output register with per-bank write enables
- broadcast mode
- per-bank fill counters with frame-complete detection
- sticky error flags

## Interface
Parameters:
- `ADDR_WIDTH`, 14: width of incoming linear address.
- `DATA_WD`, 32: BRAM word width.
- `BANK_NUM`, 16: number of banks, 2..64. Does not need to be a power of 2.
- `BANK_AW`, 8: in-bank address width, taken from `i_addr[BANK_AW-1:0]`.
- `SEL_LSB`, 9: LSB of the bank-select field. The field is `SEL_W = $clog2(BANK_NUM)` bits wide. Require `SEL_LSB >= BANK_AW` and `SEL_LSB + SEL_W <= ADDR_WIDTH`. Bits between `BANK_AW` and `SEL_LSB` are ignored.

Ports:
- `clk`, in, 1: single clock, all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `i_valid`, in, 1: write beat valid.
- `o_ready`, out, 1: block accepts a beat this cycle. Combinational: `~rst & ~o_frame_done & ~i_clear`.
- `i_addr`, in, `ADDR_WIDTH`: linear write address.
- `i_data`, in, `DATA_WD`: write data.
- `i_bcast`, in, 1: sampled with the beat; writes all banks.
- `i_frame_words`, in, `BANK_AW+1`: per-bank word target. 0 means unlimited.
- `i_clear`, in, 1: synchronous clear of counters and flags.
- `o_bank_we`, out, `BANK_NUM`: per-bank write enable, registered.
- `o_bank_addr`, out, `BANK_NUM*BANK_AW`: flattened; bank b occupies `[b*BANK_AW +: BANK_AW]`.
- `o_bank_data`, out, `BANK_NUM*DATA_WD`: flattened; bank b occupies `[b*DATA_WD +: DATA_WD]`.
- `o_bank_done`, out, `BANK_NUM`: bank counter has reached the target.
- `o_frame_done`, out, 1: level; all banks are done.
- `o_frame_done_pulse`, out, 1: one-cycle pulse on the rising edge of `o_frame_done`.
- `o_err_sel`, out, 1: sticky; a beat was received with bank select ≥ `BANK_NUM`.
- `o_err_ovf`, out, 1: sticky; a write targeted a bank that was already done.

## Operation
- **Accept.** A beat is accepted when `i_valid & o_ready`. Then `sel = i_addr[SEL_LSB +: SEL_W]` and `la = i_addr[BANK_AW-1:0]`.
- **Normal beat.** If `sel < BANK_NUM` and bank sel is not done, then:
  - `we[sel]=1`.
  - Lane sel gets `la` and `i_data`.
  - `cnt[sel]` increments.
- **Broadcast beat** (`i_bcast=1`). `sel` is ignored. Every bank that is not done gets `we=1`, `la`, `i_data`, and `cnt+1`.
- **Blocked banks.** A bank that is already done has its write suppressed and sets `o_err_ovf`.
- **Select out of range.** If `sel >= BANK_NUM` with `i_bcast=0`: no write, no counter change, `o_err_sel` set.
- **Unselected lanes.** Any lane with `we=0` drives addr=0 and data=0 in that cycle.
- **Counters.** Each `cnt[b]` is `BANK_AW+1` bits.
  - `o_bank_done[b] = (i_frame_words != 0) & (cnt[b] == i_frame_words)`. This is combinational from the registered count.
  - With `i_frame_words == 0`, counters wrap modulo `2^(BANK_AW+1)` and done never asserts.
- **Frame done.** `o_frame_done` is registered and set when all `o_bank_done` bits are 1. It holds until `i_clear` or `rst`. While it is set, `o_ready=0`.
- **Clear.** `i_clear` zeroes all counters, `o_frame_done`, `o_err_sel` and `o_err_ovf` on the next edge.
  - `o_ready` is 0 in the `i_clear` cycle, so no beat is accepted that cycle.
  - The output register (`we`/addr/data) is also zeroed.
- **Target change.** Changing `i_frame_words` mid-frame is legal and takes effect immediately for done evaluation. A target lowered below the current count never produces done.

## Timing
- **Latency.** A beat accepted at edge N produces `o_bank_we`/addr/data valid for the cycle after edge N, i.e. one cycle. The `cnt` update happens at the same edge N.
- **Throughput.** One beat per cycle. There is no bubble between consecutive beats, including to the same bank.
- **`o_bank_we` is a single-cycle pulse per accepted beat.** With no accept at edge N+1, `we` returns to 0.
- **Frame completion.**
  - The last completing beat at edge N makes the `o_bank_done` bit high in cycle N+1.
  - `o_frame_done` and `o_frame_done_pulse` go high in cycle N+2.
  - `o_ready` drops in cycle N+2. A beat offered in cycle N+1 is still accepted and flagged `o_err_ovf`.
- **`i_clear` with pending output.** The output register is zeroed at the same edge. The write presented in that cycle still occurs, because it is already on the BRAM port.
- **Reset.** All outputs are 0 after reset, except `o_ready`, which is 1 in the first cycle after `rst` deasserts. Reset mid-frame discards counters and flags.

## Test plan
- **Linear fill.** `BANK_NUM=16`, `i_frame_words=4`, addresses `sel*512 + k` for sel 0..15 and k 0..3, back-to-back.
  - 64 single-bank `we` pulses, each lane addr=k.
  - `o_frame_done_pulse` 2 cycles after the last beat; `o_ready=0` afterwards; no errors.
- **Broadcast.** Target 2; two `i_bcast` beats with addr 0x005 then 0x006.
  - `o_bank_we`=16'hFFFF on both cycles, every lane addr 5 then 6.
  - All banks done; frame done.
- **Out-of-range select.** `BANK_NUM=12`; beat with sel=13 (addr 0x1A00).
  - No `we`.
  - `o_err_sel=1` and stays 1 until `i_clear`.
- **Overflow.** Target 1; two beats to bank 3.
  - The second beat has `we[3]=0`.
  - `o_err_ovf=1`, `cnt[3]` stays 1.
- **Clear collision.** `i_valid=1` with `i_clear=1`.
  - `o_ready=0`; beat not accepted.
  - Counters and flags are 0 next cycle; the following beat is accepted normally.
- **Reset mid-frame.** Assert `rst` after 20 beats.
  - All outputs 0.
  - A refill from zero completes at exactly 64 beats.

Source files
------------

// File: rtl/bram_bank_wr_demux.sv
`default_nettype none
// ============================================================================
// Module      : bram_bank_wr_demux
// Description : Registered write demultiplexer that steers a linear write
//               stream into BANK_NUM BRAM banks. Adds valid/ready handshake,
//               broadcast writes, per-bank fill counters with frame-complete
//               detection and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_bank_wr_demux #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WD    = 32,
    parameter int BANK_NUM   = 16,
    parameter int BANK_AW    = 8,
    parameter int SEL_LSB    = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [ADDR_WIDTH-1:0]         i_addr,
    input  logic [DATA_WD-1:0]            i_data,
    input  logic                          i_bcast,
    input  logic [BANK_AW:0]              i_frame_words,
    input  logic                          i_clear,
    output logic [BANK_NUM-1:0]           o_bank_we,
    output logic [BANK_NUM*BANK_AW-1:0]   o_bank_addr,
    output logic [BANK_NUM*DATA_WD-1:0]   o_bank_data,
    output logic [BANK_NUM-1:0]           o_bank_done,
    output logic                          o_frame_done,
    output logic                          o_frame_done_pulse,
    output logic                          o_err_sel,
    output logic                          o_err_ovf
);

    // Bank-select field width and per-bank counter width.
    localparam int c_sel_w = $clog2(BANK_NUM);
    localparam int c_cnt_w = BANK_AW + 1;

    // Elaboration-time guard against an unusable address layout.
    generate
        if ((BANK_NUM < 2) || (BANK_NUM > 64) || (SEL_LSB < BANK_AW) ||
            (SEL_LSB + c_sel_w > ADDR_WIDTH)) begin : g_bad_params
            $error("bram_bank_wr_demux: illegal parameter combination");
        end
    endgenerate

    logic                  w_accept;
    logic [c_sel_w-1:0]    w_sel;
    logic                  w_sel_ok;
    logic [BANK_AW-1:0]    w_la;
    logic                  w_target_on;
    logic [BANK_NUM-1:0]   w_hit;
    logic [BANK_NUM-1:0]   w_we;
    logic [BANK_NUM-1:0]   w_done;
    logic                  w_all_done;
    logic                  w_unused_addr_bits;

    logic                  r_frame_done;
    logic                  r_frame_done_pulse;
    logic                  r_err_sel;
    logic                  r_err_ovf;

    // Beats are refused while in reset, while clearing, and once the frame
    // is complete, so a finished frame is never overwritten by stray beats.
    assign o_ready  = ~rst & ~r_frame_done & ~i_clear;
    assign w_accept = i_valid & o_ready;

    // Address decomposition; bits between the in-bank address and the
    // select field (and above it) carry no meaning here.
    assign w_sel    = i_addr[SEL_LSB +: c_sel_w];
    assign w_la     = i_addr[BANK_AW-1:0];
    assign w_sel_ok = (32'(w_sel) < 32'(BANK_NUM));
    assign w_unused_addr_bits = ^i_addr;

    // A zero target means "unlimited": counters free-run and never finish.
    assign w_target_on = |i_frame_words;
    assign w_all_done  = &w_done;

    generate
        for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
            logic [c_cnt_w-1:0] r_cnt;
            logic               r_we;
            logic [BANK_AW-1:0] r_addr;
            logic [DATA_WD-1:0] r_data;

            // Bank is addressed by this beat, either directly or by broadcast.
            assign w_hit[b]  = w_accept &
                               (i_bcast | (w_sel_ok & (w_sel == c_sel_w'(b))));
            // Done is evaluated against the live target so retargeting
            // mid-frame takes effect at once; equality means a target lowered
            // below the count simply never matches.
            assign w_done[b] = w_target_on & (r_cnt == i_frame_words);
            // Writes to a finished bank are dropped (and flagged below).
            assign w_we[b]   = w_hit[b] & ~w_done[b];

            // Per-bank fill counter, advanced on every write actually issued.
            always_ff @(posedge clk) begin
                if (rst || i_clear) begin
                    r_cnt <= '0;
                end else if (w_we[b]) begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end

            // One-cycle output register; idle lanes are driven to zero.
            always_ff @(posedge clk) begin
                if (rst || i_clear) begin
                    r_we   <= 1'b0;
                    r_addr <= '0;
                    r_data <= '0;
                end else begin
                    r_we   <= w_we[b];
                    r_addr <= w_we[b] ? w_la   : '0;
                    r_data <= w_we[b] ? i_data : '0;
                end
            end

            assign o_bank_we[b]                      = r_we;
            assign o_bank_addr[b*BANK_AW +: BANK_AW] = r_addr;
            assign o_bank_data[b*DATA_WD +: DATA_WD] = r_data;
            assign o_bank_done[b]                    = w_done[b];
        end
    endgenerate

    // Frame-complete level (held until clear) and its rising-edge pulse.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_frame_done       <= 1'b0;
            r_frame_done_pulse <= 1'b0;
        end else begin
            r_frame_done_pulse <= w_all_done & ~r_frame_done;
            if (w_all_done) begin
                r_frame_done <= 1'b1;
            end
        end
    end

    // Sticky error flags: bad bank select, and writes aimed at finished banks.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_err_sel <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_accept && !i_bcast && !w_sel_ok) begin
                r_err_sel <= 1'b1;
            end
            if (|(w_hit & w_done)) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    assign o_frame_done       = r_frame_done;
    assign o_frame_done_pulse = r_frame_done_pulse;
    assign o_err_sel          = r_err_sel;
    assign o_err_ovf          = r_err_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bram_bank_wr_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_bank_wr_demux
// Description : Directed self-checking bench for bram_bank_wr_demux, using a
//               16-bank instance and a 12-bank instance for select range.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_bank_wr_demux;

    logic         clk;
    logic         rst;
    logic         valid;
    logic         ready;
    logic [13:0]  addr;
    logic [31:0]  data;
    logic         bcast;
    logic [8:0]   frame_words;
    logic         clear;
    logic [15:0]  bank_we;
    logic [127:0] bank_addr;
    logic [511:0] bank_data;
    logic [15:0]  bank_done;
    logic         frame_done;
    logic         fd_pulse;
    logic         err_sel;
    logic         err_ovf;

    logic         valid12;
    logic         ready12;
    logic         clear12;
    logic [11:0]  we12;
    logic [95:0]  addr12;
    logic [383:0] data12;
    logic [11:0]  done12;
    logic         fd12;
    logic         fdp12;
    logic         es12;
    logic         eo12;

    int checks = 0;
    int errors = 0;

    bram_bank_wr_demux #(
        .ADDR_WIDTH(14), .DATA_WD(32), .BANK_NUM(16), .BANK_AW(8), .SEL_LSB(9)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(valid), .o_ready(ready),
        .i_addr(addr), .i_data(data), .i_bcast(bcast),
        .i_frame_words(frame_words), .i_clear(clear),
        .o_bank_we(bank_we), .o_bank_addr(bank_addr), .o_bank_data(bank_data),
        .o_bank_done(bank_done), .o_frame_done(frame_done),
        .o_frame_done_pulse(fd_pulse), .o_err_sel(err_sel), .o_err_ovf(err_ovf)
    );

    bram_bank_wr_demux #(
        .ADDR_WIDTH(14), .DATA_WD(32), .BANK_NUM(12), .BANK_AW(8), .SEL_LSB(9)
    ) dut12 (
        .clk(clk), .rst(rst), .i_valid(valid12), .o_ready(ready12),
        .i_addr(addr), .i_data(data), .i_bcast(bcast),
        .i_frame_words(frame_words), .i_clear(clear12),
        .o_bank_we(we12), .o_bank_addr(addr12), .o_bank_data(data12),
        .o_bank_done(done12), .o_frame_done(fd12),
        .o_frame_done_pulse(fdp12), .o_err_sel(es12), .o_err_ovf(eo12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [13:0] a, input logic [31:0] d, input logic b);
        valid = 1'b1;
        addr  = a;
        data  = d;
        bcast = b;
    endtask

    task automatic idle();
        valid = 1'b0;
        bcast = 1'b0;
    endtask

    initial begin
        int sel;
        int k;
        rst = 1'b1; valid = 1'b0; addr = '0; data = '0; bcast = 1'b0;
        frame_words = 9'd4; clear = 1'b0;
        valid12 = 1'b0; clear12 = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_we", 64'(bank_we), 64'h0);
        check("rst_done", 64'(bank_done), 64'h0);
        check("rst_frame_done", 64'(frame_done), 64'h0);
        check("rst_errs", 64'({err_sel, err_ovf}), 64'h0);
        check("rst_ready", 64'(ready), 64'h1);

        // Linear fill, back-to-back, target 4 words per bank
        for (int i = 0; i < 64; i++) begin
            sel = i / 4;
            k   = i % 4;
            beat(14'(sel * 512 + k), 32'hA500_0000 + 32'(i), 1'b0);
            step();
            check("fill_we", 64'(bank_we), 64'(16'(1) << sel));
            check("fill_addr", 64'(bank_addr[sel*8 +: 8]), 64'(k));
            check("fill_data", 64'(bank_data[sel*32 +: 32]), 64'(32'hA500_0000 + 32'(i)));
            check("fill_idle_lane", 64'({bank_addr[((sel+1)%16)*8 +: 8],
                                         bank_data[((sel+1)%16)*32 +: 32]}), 64'h0);
        end
        idle();
        check("fill_done_n1", 64'(bank_done), 64'hFFFF);
        check("fill_fd_n1", 64'(frame_done), 64'h0);
        step();
        check("fill_fd_n2", 64'(frame_done), 64'h1);
        check("fill_pulse_n2", 64'(fd_pulse), 64'h1);
        check("fill_ready_n2", 64'(ready), 64'h0);
        check("fill_we_n2", 64'(bank_we), 64'h0);
        step();
        check("fill_pulse_n3", 64'(fd_pulse), 64'h0);
        check("fill_errs", 64'({err_sel, err_ovf}), 64'h0);

        // Clear collision: beat offered together with clear
        beat(14'h003, 32'h1111_2222, 1'b0);
        clear = 1'b1;
        #1;
        check("clr_ready", 64'(ready), 64'h0);
        step();
        clear = 1'b0;
        #1;
        check("clr_fd", 64'(frame_done), 64'h0);
        check("clr_done", 64'(bank_done), 64'h0);
        check("clr_we", 64'(bank_we), 64'h0);
        check("clr_ready_after", 64'(ready), 64'h1);
        step();
        idle();
        check("clr_beat_we", 64'(bank_we), 64'h1);
        check("clr_beat_addr", 64'(bank_addr[7:0]), 64'h3);
        check("clr_beat_data", 64'(bank_data[31:0]), 64'h1111_2222);

        // Broadcast, target 2
        clear = 1'b1;
        step();
        clear = 1'b0;
        frame_words = 9'd2;
        beat(14'h005, 32'hCAFE_0005, 1'b1);
        step();
        check("bc1_we", 64'(bank_we), 64'hFFFF);
        check("bc1_addr7", 64'(bank_addr[7*8 +: 8]), 64'h5);
        check("bc1_data0", 64'(bank_data[31:0]), 64'hCAFE_0005);
        beat(14'h006, 32'hCAFE_0006, 1'b1);
        step();
        check("bc2_we", 64'(bank_we), 64'hFFFF);
        check("bc2_addr15", 64'(bank_addr[15*8 +: 8]), 64'h6);
        check("bc2_data3", 64'(bank_data[3*32 +: 32]), 64'hCAFE_0006);
        check("bc2_done", 64'(bank_done), 64'hFFFF);
        check("bc2_fd", 64'(frame_done), 64'h0);
        // Beat in cycle N+1 is still accepted but hits a finished bank
        beat(14'h205, 32'hDEAD_0001, 1'b0);
        #1;
        check("bc_late_ready", 64'(ready), 64'h1);
        step();
        idle();
        check("bc_late_we", 64'(bank_we), 64'h0);
        check("bc_late_ovf", 64'(err_ovf), 64'h1);
        check("bc_fd", 64'(frame_done), 64'h1);
        check("bc_pulse", 64'(fd_pulse), 64'h1);
        check("bc_ready", 64'(ready), 64'h0);

        // Overflow: target 1, two beats to bank 3
        clear = 1'b1;
        step();
        clear = 1'b0;
        frame_words = 9'd1;
        #1;
        check("ovf_cleared", 64'({err_sel, err_ovf, frame_done}), 64'h0);
        beat(14'h601, 32'h0000_0D01, 1'b0);
        step();
        check("ovf1_we", 64'(bank_we), 64'h0008);
        check("ovf1_addr", 64'(bank_addr[3*8 +: 8]), 64'h1);
        beat(14'h602, 32'h0000_0D02, 1'b0);
        step();
        idle();
        check("ovf2_we", 64'(bank_we), 64'h0);
        check("ovf2_err", 64'(err_ovf), 64'h1);
        check("ovf2_done", 64'(bank_done), 64'h0008);
        frame_words = 9'd2;
        #1;
        check("ovf_cnt_held", 64'(bank_done), 64'h0);
        check("ovf_no_sel_err", 64'(err_sel), 64'h0);

        // Out-of-range select on the 12-bank instance
        addr = 14'h1A00; data = 32'h0BAD_0BAD; bcast = 1'b0;
        valid12 = 1'b1;
        step();
        valid12 = 1'b0;
        check("oor_we", 64'(we12), 64'h0);
        check("oor_err", 64'(es12), 64'h1);
        check("oor_no_ovf", 64'(eo12), 64'h0);
        addr = 14'h1601; data = 32'h0000_0B0B;
        valid12 = 1'b1;
        step();
        valid12 = 1'b0;
        check("oor_inrange_we", 64'(we12), 64'h800);
        check("oor_inrange_addr", 64'(addr12[11*8 +: 8]), 64'h1);
        check("oor_err_sticky", 64'(es12), 64'h1);
        clear12 = 1'b1;
        step();
        clear12 = 1'b0;
        check("oor_err_cleared", 64'(es12), 64'h0);

        // Reset mid-frame, then full refill
        clear = 1'b1;
        step();
        clear = 1'b0;
        frame_words = 9'd4;
        for (int i = 0; i < 20; i++) begin
            beat(14'((i / 4) * 512 + (i % 4)), 32'(i), 1'b0);
            step();
        end
        idle();
        rst = 1'b1;
        step();
        check("mrst_we", 64'(bank_we), 64'h0);
        check("mrst_lanes", 64'({|bank_addr, |bank_data}), 64'h0);
        check("mrst_done", 64'(bank_done), 64'h0);
        check("mrst_flags", 64'({frame_done, fd_pulse, err_sel, err_ovf}), 64'h0);
        check("mrst_ready_in_rst", 64'(ready), 64'h0);
        rst = 1'b0;
        #1;
        check("mrst_ready", 64'(ready), 64'h1);
        for (int i = 0; i < 64; i++) begin
            beat(14'((i / 4) * 512 + (i % 4)), 32'h5000_0000 + 32'(i), 1'b0);
            step();
            if (i == 62) begin
                check("refill_63", 64'(bank_done), 64'h7FFF);
            end
        end
        idle();
        check("refill_64", 64'(bank_done), 64'hFFFF);
        step();
        check("refill_fd", 64'(frame_done), 64'h1);
        check("refill_pulse", 64'(fd_pulse), 64'h1);
        check("refill_errs", 64'({err_sel, err_ovf}), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
